// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer for the MIPS core.
// Owns the PC, runs the imem req/ack handshake, presents one instruction
// at a time to decode and applies branch-unit redirects on consume.
// Optional macro BRANCH_DELAY_SLOT_EN: defers each taken redirect by one
// instruction (the delay slot is fetched first).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] tgt_aligned;
    logic        consume;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
`endif

    // Word-align the redirect target; the low two bits are never used.
    assign tgt_aligned = br_target & 32'hFFFF_FFFC;
    assign consume     = (state_q == S_VALID) && !stall;

    // Outputs come straight from registered state, no input feedthrough.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == S_VALID);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign retire_cnt = retire_q;

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            retire_q  <= retire_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // Pending redirect waiting for the delay slot to be consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end
`endif

    // Next-state and datapath update; the PC only moves on a consume.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        retire_d  = retire_q;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`endif
        case (state_q)
            S_BOOT: begin
                // Any ack seen here belongs to an abandoned request.
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                if (consume) begin
                    retire_d = retire_q + 32'd1;
                    state_d  = S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (pend_valid_q) begin
                        // Delay slot retired: take the deferred redirect,
                        // ignoring any branch flagged on this instruction.
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                    end else if (br_taken) begin
                        pc_d          = pc_q + 32'd4;
                        pend_valid_d  = 1'b1;
                        pend_target_d = tgt_aligned;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
`else
                    pc_d = br_taken ? tgt_aligned : (pc_q + 32'd4);
`endif
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the MIPS core. It owns the program counter and drives the instruction-memory request/acknowledge handshake. It presents one fetched instruction at a time to decode and applies redirects from the branch unit, using that unit's taken flag and target address. An optional delay-slot mode defers each redirect by one instruction.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: downstream not ready; hold the presented instruction.
- `br_taken` in 1: redirect request from the branch unit, qualified by a consume (see Operation).
- `br_target` in 32: redirect byte address.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; equals the PC.
- `imem_ack` in 1: memory returns data this cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`=1.
- `inst_valid` out 1: `inst` and `inst_pc` hold a live instruction.
- `inst` out 32: presented instruction word.
- `inst_pc` out 32: address of `inst`.
- `retire_cnt` out 32: number of instructions consumed.

## Operation
- A consume occurs when `inst_valid`=1 and `stall`=0.
- FSM states: BOOT, FETCH, VALID.
  - BOOT: entered on reset. Lasts exactly one cycle after `rst` deasserts, then goes to FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=pc.
    - Stays in FETCH until `imem_ack`=1.
    - On `imem_ack`=1: `inst`<=`imem_rdata`, `inst_pc`<=pc, go to VALID.
  - VALID: `inst_valid`=1 and `imem_req`=0.
    - `stall`=1: stay in VALID. `inst` and `inst_pc` hold their values.
    - Consume: compute next pc (rules below), `retire_cnt`+=1, go to FETCH.
- Next pc on consume, without delay slot:
  - `br_taken`=1: pc<=`{br_target[31:2],2'b00}`.
  - `br_taken`=0: pc<=pc+4.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- `br_target[1:0]` is always discarded.
- `br_taken` is ignored in any cycle that is not a consume.
- `retire_cnt` wraps from 32'hFFFF_FFFF to 0.
- `imem_ack` arriving while `imem_req`=0 is ignored.
- Reset values:
  - state=BOOT, pc=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - `retire_cnt`=0.
  - Pending-redirect state cleared.
- Reset mid-fetch: the outstanding request is abandoned immediately. A late `imem_ack` during BOOT is ignored.

## Timing
- `imem_req`, `imem_addr` and `inst_valid` are decoded from registered state only. There is no combinational path from any input to any output.
- `imem_ack` may arrive in the first cycle `imem_req` is high.
- Zero-wait memory:
  - FETCH in cycle N, `inst_valid`=1 in cycle N+1.
  - Back-to-back consumes give 1 instruction per 2 cycles.
- Each wait cycle with `imem_ack`=0 adds one cycle. During wait cycles `imem_addr` is stable.
- A redirect takes effect on the `imem_addr` of the FETCH cycle that immediately follows the consume.
- First request after reset: `imem_req`=1 in the second rising-edge cycle after `rst` falls (BOOT, then FETCH).

## Configuration
- `BRANCH_DELAY_SLOT_EN` undefined: redirect is immediate, as described in Operation.
- `BRANCH_DELAY_SLOT_EN` defined:
  - Consume with `br_taken`=1 and no pending redirect:
    - pc<=pc+4 (fetch the delay slot).
    - pend_valid<=1, pend_target<={br_target[31:2],2'b00}.
  - Next consume (the delay slot): pc<=pend_target, pend_valid<=0. `br_taken` on this consume is ignored.
  - `stall` on the delay-slot instruction preserves the pending state.
  - Reset clears pend_valid.

## Test plan
1. Reset release, zero-wait memory, no branches:
   - `imem_addr` sequence is 3000, 3004, 3008.
   - `inst_pc` tracks `imem_addr`.
   - `retire_cnt`=3 after three consumes.
2. Ack delayed 3 cycles on address 3004, plus `stall`=1 for 2 cycles while `inst_pc`=3004:
   - `imem_addr` is held at 3004 for 4 cycles.
   - `inst` is held for the 2 stall cycles.
   - No extra retire is counted.
3. Consume of 3008 with `br_taken`=1 and `br_target`=32'h0000_4003:
   - Next `imem_addr`=4000.
   - `br_taken`=1 while `stall`=1 is ignored.
4. Reset asserted mid-FETCH at 4000, with `imem_ack` pulsed during BOOT:
   - All outputs return to their reset values.
   - The next fetch address is 3000.
   - `inst_valid` stays 0 until a new ack arrives.
5. pc=32'hFFFF_FFFC, consume without branch: next `imem_addr`=0.
6. With `BRANCH_DELAY_SLOT_EN` defined, consume of 3008 with `br_taken`=1 and `br_target`=5000:
   - Fetch sequence is 300C (delay slot), then 5000.
   - `br_taken`=1 with target 6000 on the 300C consume is ignored.
